responder_arbiter: RTL and testbench

- Quiz-responder controller: arbitrates debounced player key presses, locks the first valid responder, and runs a per-answer countdown with buzzer cues.
- Sits downstream of the per-key debounce/edge-detect filters.
- Drives the display/LED and buzzer logic.
- Host start/clear keys sequence the round.

---
 rtl/responder_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_responder_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/responder_arbiter.sv
// Quiz-responder controller: locks the first eligible player press and runs the answer countdown and buzzer.
// Optional round-robin priority is built when RESPONDER_ROTATE_PRIO_EN is defined.
module responder_arbiter #(
  parameter int N_PLAYER    = 4,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int ANSWER_SEC  = 30,
  parameter int BUZZ_CYCLES = 10_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_pulse,
  input  logic                        clear_pulse,
  input  logic [N_PLAYER-1:0]         key_pulse,
  output logic                        winner_valid,
  output logic [$clog2(N_PLAYER)-1:0] winner_id,
  output logic [N_PLAYER-1:0]         winner_onehot,
  output logic [N_PLAYER-1:0]         foul,
  output logic [1:0]                  state_o,
  output logic [7:0]                  sec_left,
  output logic                        buzzer
);

  localparam int IW = $clog2(N_PLAYER);
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES + 1) : 1;
  localparam logic [PW-1:0]       PRESC_TC  = PW'(CLK_FREQ - 1);
  localparam logic [BW-1:0]       BUZZ_LOAD = BW'(BUZZ_CYCLES);
  localparam logic [7:0]          SEC_LOAD  = 8'(ANSWER_SEC);
  localparam logic [N_PLAYER-1:0] ONE_HOT0  = {{(N_PLAYER-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [PW-1:0]       presc_r, presc_s;
  logic [BW-1:0]       buzz_cnt_r, buzz_cnt_s;
  logic                buzzer_r;
  logic                wv_r, wv_s;
  logic [IW-1:0]       wid_r, wid_s;
  logic [N_PLAYER-1:0] woh_r, woh_s;
  logic [N_PLAYER-1:0] foul_r, foul_s;
  logic [7:0]          sec_r, sec_s;
  logic                buzz_evt_s;
  logic [IW:0]         pick_s;
  logic [IW-1:0]       ptr_cur_s;

  // Search eligible presses starting at ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IW:0] pick_winner(input logic [N_PLAYER-1:0] elig,
                                              input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] idx;
    found = 1'b0;
    idx   = {IW{1'b0}};
    for (int k = 0; k < N_PLAYER; k++) begin
      int j;
      j = (int'(ptr) + k) % N_PLAYER;
      if (!found && elig[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

`ifdef RESPONDER_ROTATE_PRIO_EN
  logic [IW-1:0] ptr_r, ptr_s;
  assign ptr_cur_s = ptr_r;

  // Pointer advances past each new winner; clear_pulse leaves it alone.
  always_comb begin
    ptr_s = ptr_r;
    if (!clear_pulse && (state_r == ST_ARMED) && pick_s[IW]) begin
      ptr_s = (pick_s[IW-1:0] == IW'(N_PLAYER - 1)) ? {IW{1'b0}} : pick_s[IW-1:0] + IW'(1);
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {IW{1'b0}};
    end else begin
      ptr_r <= ptr_s;
    end
  end
`else
  assign ptr_cur_s = {IW{1'b0}};
`endif

  // Next-state and next-datapath logic; clear_pulse overrides everything else.
  always_comb begin
    state_s    = state_r;
    presc_s    = presc_r;
    buzz_cnt_s = (buzz_cnt_r != {BW{1'b0}}) ? buzz_cnt_r - BW'(1) : {BW{1'b0}};
    wv_s       = wv_r;
    wid_s      = wid_r;
    woh_s      = woh_r;
    foul_s     = foul_r;
    sec_s      = sec_r;
    buzz_evt_s = 1'b0;
    pick_s     = pick_winner(key_pulse & ~foul_r, ptr_cur_s);

    if (clear_pulse) begin
      state_s    = ST_IDLE;
      presc_s    = {PW{1'b0}};
      buzz_cnt_s = {BW{1'b0}};
      wv_s       = 1'b0;
      wid_s      = {IW{1'b0}};
      woh_s      = {N_PLAYER{1'b0}};
      foul_s     = {N_PLAYER{1'b0}};
      sec_s      = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wv_s    = 1'b0;
          wid_s   = {IW{1'b0}};
          woh_s   = {N_PLAYER{1'b0}};
          sec_s   = 8'd0;
          presc_s = {PW{1'b0}};
          foul_s  = foul_r | key_pulse;
          if (|key_pulse) buzz_evt_s = 1'b1;
          else            buzz_evt_s = 1'b0;
          if (start_pulse) state_s = ST_ARMED;
          else             state_s = ST_IDLE;
        end
        ST_ARMED: begin
          if (pick_s[IW]) begin
            state_s    = ST_LOCKED;
            wv_s       = 1'b1;
            wid_s      = pick_s[IW-1:0];
            woh_s      = ONE_HOT0 << pick_s[IW-1:0];
            sec_s      = SEC_LOAD;
            presc_s    = {PW{1'b0}};
            buzz_evt_s = 1'b1;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_LOCKED: begin
          if (presc_r == PRESC_TC) begin
            presc_s = {PW{1'b0}};
            if (sec_r <= 8'd1) begin
              sec_s      = 8'd0;
              state_s    = ST_TIMEOUT;
              buzz_evt_s = 1'b1;
            end else begin
              sec_s = sec_r - 8'd1;
            end
          end else begin
            presc_s = presc_r + PW'(1);
          end
        end
        ST_TIMEOUT: begin
          sec_s = 8'd0;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
      if (buzz_evt_s) buzz_cnt_s = BUZZ_LOAD;
      else            buzz_cnt_s = buzz_cnt_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; buzzer reflects the counter value being loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r    <= {PW{1'b0}};
      buzz_cnt_r <= {BW{1'b0}};
      buzzer_r   <= 1'b0;
      wv_r       <= 1'b0;
      wid_r      <= {IW{1'b0}};
      woh_r      <= {N_PLAYER{1'b0}};
      foul_r     <= {N_PLAYER{1'b0}};
      sec_r      <= 8'd0;
    end else begin
      presc_r    <= presc_s;
      buzz_cnt_r <= buzz_cnt_s;
      buzzer_r   <= (buzz_cnt_s != {BW{1'b0}});
      wv_r       <= wv_s;
      wid_r      <= wid_s;
      woh_r      <= woh_s;
      foul_r     <= foul_s;
      sec_r      <= sec_s;
    end
  end

  assign state_o       = state_r;
  assign winner_valid  = wv_r;
  assign winner_id     = wid_r;
  assign winner_onehot = woh_r;
  assign foul          = foul_r;
  assign sec_left      = sec_r;
  assign buzzer        = buzzer_r;

endmodule

// File: tb/tb_responder_arbiter.sv
// Scoreboard bench for responder_arbiter: a cycle-level reference model queues expected outputs, a monitor compares.
module tb_responder_arbiter;

  localparam int NP = 4;
  localparam int CF = 10;
  localparam int AS = 3;
  localparam int BZ = 5;

  logic       clk;
  logic       rst;
  logic       start_pulse;
  logic       clear_pulse;
  logic [3:0] key_pulse;
  logic       winner_valid;
  logic [1:0] winner_id;
  logic [3:0] winner_onehot;
  logic [3:0] foul;
  logic [1:0] state_o;
  logic [7:0] sec_left;
  logic       buzzer;

  responder_arbiter #(
    .N_PLAYER(NP), .CLK_FREQ(CF), .ANSWER_SEC(AS), .BUZZ_CYCLES(BZ)
  ) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .clear_pulse(clear_pulse),
    .key_pulse(key_pulse), .winner_valid(winner_valid), .winner_id(winner_id),
    .winner_onehot(winner_onehot), .foul(foul), .state_o(state_o),
    .sec_left(sec_left), .buzzer(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st; int wv; int wid; int woh; int foul; int sec; int buz;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state, expressed in rounds/elapsed cycles rather than counters
  int   m_st, m_wv, m_wid, m_foul, m_sec, m_lock_t, m_buzz_until, m_t, m_ptr;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input int elig, input int ptr);
    for (int k = 0; k < NP; k++) begin
      int idx;
      idx = (ptr + k) % NP;
      if (((elig >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_wv = 0; m_wid = 0; m_foul = 0; m_sec = 0;
    m_lock_t = 0; m_buzz_until = 0; m_t = 0; m_ptr = 0;
  endtask

  task automatic model_step(input int s, input int c, input int k);
    exp_t e;
    int   w;
    m_t++;
    if (c != 0) begin
      m_st = 0; m_wv = 0; m_wid = 0; m_foul = 0; m_sec = 0; m_buzz_until = m_t;
    end else begin
      case (m_st)
        0: begin
          m_foul = m_foul | k;
          if (k != 0) m_buzz_until = m_t + BZ;
          if (s != 0) m_st = 1;
        end
        1: begin
          w = model_pick(k & ~m_foul & 15, m_ptr);
          if (w >= 0) begin
            m_st = 2; m_wv = 1; m_wid = w; m_sec = AS; m_lock_t = m_t;
            m_buzz_until = m_t + BZ;
`ifdef RESPONDER_ROTATE_PRIO_EN
            m_ptr = (w + 1) % NP;
`endif
          end
        end
        2: begin
          m_sec = AS - (m_t - m_lock_t) / CF;
          if (m_sec <= 0) begin
            m_sec = 0; m_st = 3; m_buzz_until = m_t + BZ;
          end
        end
        default: ;
      endcase
    end
    e.st = m_st; e.wv = m_wv; e.wid = m_wid;
    e.woh = (m_wv != 0) ? (1 << m_wid) : 0;
    e.foul = m_foul; e.sec = m_sec;
    e.buz = (m_t < m_buzz_until) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic drive(input logic s, input logic c, input logic [3:0] k);
    @(negedge clk);
    start_pulse = s; clear_pulse = c; key_pulse = k;
    model_step(int'(s), int'(c), int'(k));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_state"}, int'(state_o), 0);
    cmp({tag, "_wv"}, int'(winner_valid), 0);
    cmp({tag, "_wid"}, int'(winner_id), 0);
    cmp({tag, "_woh"}, int'(winner_onehot), 0);
    cmp({tag, "_foul"}, int'(foul), 0);
    cmp({tag, "_sec"}, int'(sec_left), 0);
    cmp({tag, "_buzzer"}, int'(buzzer), 0);
  endtask

  // Monitor: one expected snapshot per active edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("state", int'(state_o), e.st);
        cmp("winner_valid", int'(winner_valid), e.wv);
        cmp("winner_id", int'(winner_id), e.wid);
        cmp("winner_onehot", int'(winner_onehot), e.woh);
        cmp("foul", int'(foul), e.foul);
        cmp("sec_left", int'(sec_left), e.sec);
        cmp("buzzer", int'(buzzer), e.buz);
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start_pulse = 1'b0; clear_pulse = 1'b0; key_pulse = 4'b0000;
    model_reset();
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // first lock and full countdown to timeout
    idle(1);
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0100);
    @(posedge clk); #2;
    cmp("lock_state", int'(state_o), 2);
    cmp("lock_id", int'(winner_id), 2);
    cmp("lock_onehot", int'(winner_onehot), 4);
    cmp("lock_sec", int'(sec_left), AS);
    cmp("lock_buzzer", int'(buzzer), 1);
    idle(32);
    cmp("timeout_state", int'(state_o), 3);
    drive(1'b0, 1'b1, 4'b0000);

    // simultaneous presses, presses while locked, clear+start together
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b1010);
    drive(1'b0, 1'b0, 4'b1111);
    drive(1'b1, 1'b0, 4'b1111);
    idle(3);
    drive(1'b1, 1'b1, 4'b0000);
    idle(2);

    // early press fouls, fouled player ignored, next player wins
    drive(1'b0, 1'b0, 4'b0001);
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0001);
    idle(2);
    drive(1'b0, 1'b0, 4'b0010);
    idle(1);
    drive(1'b0, 1'b1, 4'b0000);

    // everyone fouled: stays armed
    drive(1'b0, 1'b0, 4'b1111);
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b1111);
    drive(1'b0, 1'b0, 4'b0110);
    idle(2);
    drive(1'b0, 1'b1, 4'b0000);

    // asynchronous reset mid-countdown
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b1000);
    idle(14);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start_pulse = 1'b0; clear_pulse = 1'b0; key_pulse = 4'b0000;
    model_reset();

    // randomized rounds
    for (int i = 0; i < 700; i++) begin
      logic       rs, rc;
      logic [3:0] rk;
      rc = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 99) < 12);
      for (int b = 0; b < 4; b++) rk[b] = ($urandom_range(0, 9) == 0);
      drive(rs, rc, rk);
    end
    idle(1);

    @(posedge clk); #3;
    cmp("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
